// File: rtl/capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : capture_pkg
//  Description : Shared types and helpers for the sample capture/dump block:
//                FSM state encoding, ASCII constants (line terminators and
//                command bytes), hex-digit-to-ASCII conversion and the
//                number of hex characters needed for a given sample width.
//  Revision    : 1.0  initial release
// ============================================================================
package capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DUMP    = 2'd3
    } state_t;

    localparam logic [7:0] c_LF          = 8'h0A;
    localparam logic [7:0] c_CR          = 8'h0D;
    localparam logic [7:0] c_CMD_START_L = 8'h73;  // 's'
    localparam logic [7:0] c_CMD_START_U = 8'h53;  // 'S'
    localparam logic [7:0] c_CMD_ABORT_L = 8'h61;  // 'a'
    localparam logic [7:0] c_CMD_ABORT_U = 8'h41;  // 'A'
    localparam logic [7:0] c_CMD_TRIG_L  = 8'h74;  // 't'
    localparam logic [7:0] c_CMD_TRIG_U  = 8'h54;  // 'T'

    // Uppercase hex: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // Hex characters per sample, top nibble zero-padded
    function automatic int nib_count(input int width);
        return (width + 3) / 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/capture_ram.sv
`default_nettype none
// ============================================================================
//  Module      : capture_ram
//  Description : Simple dual-port sample buffer, one write port and one
//                registered read port (1-cycle read latency), written so it
//                maps onto block RAM. Contents are not reset.
//  Ports       : clk      - clock
//                i_we     - write enable
//                i_waddr  - write address
//                i_wdata  - write data
//                i_raddr  - read address (sampled every cycle)
//                o_rdata  - registered read data
//  Revision    : 1.0  initial release
// ============================================================================
module capture_ram
    import capture_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/sample_capture_dump.sv
`default_nettype none
// ============================================================================
//  Module      : sample_capture_dump
//  Description : Captures DEPTH samples (every DECIMATE-th valid sample) on a
//                UART 's' command and streams them out as uppercase hex ASCII
//                lines (MSB nibble first, then LF, CR) over a byte valid/ready
//                interface, with GAP_CYCLES idle cycles between bytes. 'a'
//                aborts capture or dump (an in-flight byte always completes).
//                Optional feature macro CAPTURE_TRIGGER_EN adds a 't' command
//                that arms a level trigger (sample_data >= TRIG_LEVEL).
//  Ports       : clk, rst (async, active-high)
//                sample_data/sample_valid - ADC sample stream
//                rx_data/rx_valid/rx_ready - command bytes from uart
//                tx_data/tx_valid/tx_ready - ASCII bytes to uart
//                busy                      - not idle
//  Revision    : 1.0  initial release
// ============================================================================
module sample_capture_dump
    import capture_pkg::*;
#(
    parameter int          SAMPLE_WIDTH = 24,
    parameter int          DEPTH        = 1024,
    parameter int          DECIMATE     = 1,
    parameter int          GAP_CYCLES   = 100,
    parameter logic [63:0] TRIG_LEVEL   = 64'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic                    sample_valid,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
    localparam int GW    = $clog2(GAP_CYCLES + 2);
    localparam int NIB   = nib_count(SAMPLE_WIDTH);
    localparam int NW    = $clog2(NIB + 2);

    localparam logic [AW-1:0] c_PTR_LAST = AW'(DEPTH - 1);
    localparam logic [DW-1:0] c_DEC_LAST = DW'(DECIMATE - 1);
    // Load value covers the gap plus the one-cycle RAM read latency
    localparam logic [GW-1:0] c_GAP_LOAD = GW'(GAP_CYCLES + 1);
    localparam logic [NW-1:0] c_NIB_TOP  = NW'(NIB - 1);
    localparam logic [NW-1:0] c_NIB_LF   = NW'(NIB);
    localparam logic [NW-1:0] c_NIB_CR   = NW'(NIB + 1);

    state_t                  r_state;
    logic                    r_rx_ready;
    logic                    r_tx_valid;
    logic [7:0]              r_tx_data;
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_idx;
    logic [DW-1:0]           r_dec;
    logic [NW-1:0]           r_nib;
    logic [GW-1:0]           r_wait;
    logic                    r_abort;

    logic                    w_fire;
    logic                    w_cmd_start;
    logic                    w_cmd_abort;
    logic                    w_we;
    logic [AW-1:0]           w_waddr;
    logic [SAMPLE_WIDTH-1:0] w_rdata;
    logic [NIB*4-1:0]        w_q_ext;
    logic [NW-1:0]           w_idx;
    logic [3:0]              w_nibble;
    logic [7:0]              w_char;

    assign w_fire      = rx_valid & r_rx_ready;
    assign w_cmd_start = w_fire & ((rx_data == c_CMD_START_L) | (rx_data == c_CMD_START_U));
    assign w_cmd_abort = w_fire & ((rx_data == c_CMD_ABORT_L) | (rx_data == c_CMD_ABORT_U));

`ifdef CAPTURE_TRIGGER_EN
    logic w_cmd_trig;
    logic w_trig_hit;
    assign w_cmd_trig = w_fire & ((rx_data == c_CMD_TRIG_L) | (rx_data == c_CMD_TRIG_U));
    assign w_trig_hit = sample_valid & (64'(sample_data) >= TRIG_LEVEL);
`else
    logic w_unused_trig;
    assign w_unused_trig = ^TRIG_LEVEL;
`endif

    // Buffer write: decimated samples in CAPTURE, trigger sample to index 0 in ARM
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_wr_ptr;
        if ((r_state == ST_CAPTURE) && sample_valid && !w_cmd_abort && (r_dec == c_DEC_LAST)) begin
            w_we = 1'b1;
        end
`ifdef CAPTURE_TRIGGER_EN
        if ((r_state == ST_ARM) && w_trig_hit && !w_cmd_abort) begin
            w_we    = 1'b1;
            w_waddr = '0;
        end
`endif
    end

    capture_ram #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (sample_data),
        .i_raddr (r_rd_idx),
        .o_rdata (w_rdata)
    );

    // Character for the current position within the line of r_rd_idx
    always_comb begin
        w_q_ext                     = '0;
        w_q_ext[SAMPLE_WIDTH-1:0]   = w_rdata;
        w_idx                       = c_NIB_TOP - r_nib;
        w_nibble                    = 4'(w_q_ext >> {w_idx, 2'b00});
        if (r_nib == c_NIB_LF) begin
            w_char = c_LF;
        end else if (r_nib == c_NIB_CR) begin
            w_char = c_CR;
        end else begin
            w_char = hex_ascii(w_nibble);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rx_ready <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_wr_ptr   <= '0;
            r_rd_idx   <= '0;
            r_dec      <= '0;
            r_nib      <= '0;
            r_wait     <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_rx_ready <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_start) begin
                        r_state  <= ST_CAPTURE;
                        r_wr_ptr <= '0;
                        r_dec    <= '0;
                        r_rd_idx <= '0;
                    end
`ifdef CAPTURE_TRIGGER_EN
                    else if (w_cmd_trig) begin
                        r_state  <= ST_ARM;
                        r_wr_ptr <= '0;
                        r_dec    <= '0;
                        r_rd_idx <= '0;
                    end
`endif
                end
`ifdef CAPTURE_TRIGGER_EN
                ST_ARM: begin
                    if (w_cmd_abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_trig_hit) begin
                        // trigger sample occupies index 0 and restarts decimation
                        r_state  <= ST_CAPTURE;
                        r_wr_ptr <= AW'(1);
                        r_dec    <= '0;
                    end
                end
`endif
                ST_CAPTURE: begin
                    if (w_cmd_abort) begin
                        r_state <= ST_IDLE;
                    end else if (sample_valid) begin
                        if (r_dec == c_DEC_LAST) begin
                            r_dec    <= '0;
                            r_wr_ptr <= r_wr_ptr + AW'(1);
                            if (r_wr_ptr == c_PTR_LAST) begin
                                r_state <= ST_DUMP;
                                r_nib   <= '0;
                                r_wait  <= c_GAP_LOAD;
                                r_abort <= 1'b0;
                            end
                        end else begin
                            r_dec <= r_dec + DW'(1);
                        end
                    end
                end
                ST_DUMP: begin
                    if (r_tx_valid) begin
                        // a byte on the wire is never withdrawn; abort waits for it
                        if (w_cmd_abort) begin
                            r_abort <= 1'b1;
                        end
                        if (tx_ready) begin
                            r_tx_valid <= 1'b0;
                            r_wait     <= c_GAP_LOAD;
                            if (r_abort || w_cmd_abort) begin
                                r_state <= ST_IDLE;
                            end else if (r_nib == c_NIB_CR) begin
                                r_nib <= '0;
                                if (r_rd_idx == c_PTR_LAST) begin
                                    r_state <= ST_IDLE;
                                end else begin
                                    r_rd_idx <= r_rd_idx + AW'(1);
                                end
                            end else begin
                                r_nib <= r_nib + NW'(1);
                            end
                        end
                    end else if (w_cmd_abort) begin
                        r_state <= ST_IDLE;
                    end else if (r_wait == '0) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_char;
                    end else begin
                        r_wait <= r_wait - GW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_ready = r_rx_ready;
    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sample_capture_dump.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_capture_dump
//  Description : Directed bench for sample_capture_dump. Three instances:
//                  0: W=24 D=4 DEC=1 GAP=0 (TRIG_LEVEL 0x800000)
//                  1: W=10 D=2 DEC=1 GAP=0
//                  2: W=24 D=2 DEC=3 GAP=5
//                A negedge monitor collects transmitted bytes and checks
//                tx hold stability and handshake-to-next-byte spacing.
//                Trigger scenario compiled in with CAPTURE_TRIGGER_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sample_capture_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] sd  [3];
    logic        sv  [3];
    logic [7:0]  rxd [3];
    logic        rxv [3];
    logic        rxr [3];
    logic [7:0]  td  [3];
    logic        tv  [3];
    logic        tr  [3];
    logic        bsy [3];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    string       rx_str  [3];
    int          last_hs [3];
    logic        prev_tv [3];
    logic        prev_hs [3];
    logic [7:0]  prev_td [3];

    sample_capture_dump #(
        .SAMPLE_WIDTH(24), .DEPTH(4), .DECIMATE(1), .GAP_CYCLES(0), .TRIG_LEVEL(64'h800000)
    ) u_dut0 (
        .clk(clk), .rst(rst), .sample_data(sd[0]), .sample_valid(sv[0]),
        .rx_data(rxd[0]), .rx_valid(rxv[0]), .rx_ready(rxr[0]),
        .tx_data(td[0]), .tx_valid(tv[0]), .tx_ready(tr[0]), .busy(bsy[0])
    );

    sample_capture_dump #(
        .SAMPLE_WIDTH(10), .DEPTH(2), .DECIMATE(1), .GAP_CYCLES(0)
    ) u_dut1 (
        .clk(clk), .rst(rst), .sample_data(sd[1][9:0]), .sample_valid(sv[1]),
        .rx_data(rxd[1]), .rx_valid(rxv[1]), .rx_ready(rxr[1]),
        .tx_data(td[1]), .tx_valid(tv[1]), .tx_ready(tr[1]), .busy(bsy[1])
    );

    sample_capture_dump #(
        .SAMPLE_WIDTH(24), .DEPTH(2), .DECIMATE(3), .GAP_CYCLES(5)
    ) u_dut2 (
        .clk(clk), .rst(rst), .sample_data(sd[2]), .sample_valid(sv[2]),
        .rx_data(rxd[2]), .rx_valid(rxv[2]), .rx_ready(rxr[2]),
        .tx_data(td[2]), .tx_valid(tv[2]), .tx_ready(tr[2]), .busy(bsy[2])
    );

    function automatic int gap_of(input int k);
        return (k == 2) ? 5 : 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte collection, hold stability and byte spacing
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                prev_tv[k] = 1'b0;
                prev_hs[k] = 1'b0;
            end else begin
                if (prev_tv[k] && !prev_hs[k]) begin
                    check("hold_valid", {63'd0, tv[k]}, 64'd1);
                    check("hold_data", {56'd0, td[k]}, {56'd0, prev_td[k]});
                end
                if (tv[k] && !prev_tv[k] && (last_hs[k] >= 0)) begin
                    check("byte_spacing", 64'(cyc - last_hs[k]), 64'(gap_of(k) + 3));
                end
                if (tv[k] && tr[k]) begin
                    rx_str[k] = $sformatf("%s%c", rx_str[k], td[k]);
                    last_hs[k] = cyc;
                end
                prev_tv[k] = tv[k];
                prev_hs[k] = tv[k] && tr[k];
                prev_td[k] = td[k];
            end
        end
    end

    task automatic start_dump(input int k);
        rx_str[k]  = "";
        last_hs[k] = -1;
    endtask

    task automatic send_cmd(input int k, input logic [7:0] b);
        @(posedge clk); #1;
        rxd[k] = b;
        rxv[k] = 1'b1;
        @(posedge clk); #1;
        rxv[k] = 1'b0;
    endtask

    task automatic feed(input int k, input logic [23:0] v);
        @(posedge clk); #1;
        sd[k] = v;
        sv[k] = 1'b1;
        @(posedge clk); #1;
        sv[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget, input bit rnd);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (!bsy[k]) break;
            if (n >= budget) begin
                check("idle_timeout", {63'd0, bsy[k]}, 64'd0);
                break;
            end
            @(posedge clk); #1;
            if (rnd) tr[k] = 1'($urandom_range(0, 1));
            n++;
        end
        tr[k] = 1'b1;
    endtask

    task automatic wait_tv(input int k, input int budget);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (tv[k]) break;
            if (n >= budget) begin
                check("valid_timeout", {63'd0, tv[k]}, 64'd1);
                break;
            end
            n++;
        end
    endtask

    task automatic cmp_str(input int k, input string tag, input string exp);
        int m;
        check({tag, "_len"}, 64'(rx_str[k].len()), 64'(exp.len()));
        m = (rx_str[k].len() < exp.len()) ? rx_str[k].len() : exp.len();
        for (int i = 0; i < m; i++) begin
            check(tag, {56'd0, rx_str[k][i]}, {56'd0, exp[i]});
        end
    endtask

    string e_main, e_w10, e_dec, e_abort, e_trig;

    initial begin
        e_main  = "000001\n\01500ABCD\n\015FFFFFF\n\015123456\n\015";
        e_w10   = "3FF\n\01500A\n\015";
        e_dec   = "000003\n\015000006\n\015";
        e_abort = "00A";
        e_trig  = "800000\n\015000020\n\015000001\n\015000002\n\015";
        for (int k = 0; k < 3; k++) begin
            sd[k] = '0; sv[k] = 1'b0; rxd[k] = '0; rxv[k] = 1'b0; tr[k] = 1'b1;
            rx_str[k] = ""; last_hs[k] = -1;
            prev_tv[k] = 1'b0; prev_hs[k] = 1'b0; prev_td[k] = '0;
        end

        // ---------------- reset ----------------
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_rx_ready", {63'd0, rxr[k]}, 64'd0);
            check("rst_tx_valid", {63'd0, tv[k]}, 64'd0);
            check("rst_tx_data", {56'd0, td[k]}, 64'd0);
            check("rst_busy", {63'd0, bsy[k]}, 64'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rx_ready_after_rst", {63'd0, rxr[0]}, 64'd1);

        // ---------------- main dump, first-byte latency ----------------
        start_dump(0);
        send_cmd(0, 8'h73);
        @(negedge clk);
        check("busy_after_s", {63'd0, bsy[0]}, 64'd1);
        feed(0, 24'h000001);
        feed(0, 24'h00ABCD);
        feed(0, 24'hFFFFFF);
        feed(0, 24'h123456);
        @(negedge clk); check("lat_n1", {63'd0, tv[0]}, 64'd0);
        @(negedge clk); check("lat_n2", {63'd0, tv[0]}, 64'd0);
        @(negedge clk); check("lat_n3", {63'd0, tv[0]}, 64'd1);
        wait_idle(0, 200, 1'b0);
        cmp_str(0, "main", e_main);
        check("main_busy", {63'd0, bsy[0]}, 64'd0);

        // ---------------- W=10, unknown bytes, sample on accept cycle ----------------
        send_cmd(1, 8'h78);
`ifndef CAPTURE_TRIGGER_EN
        send_cmd(1, 8'h74);
`endif
        @(negedge clk);
        check("unknown_ignored", {63'd0, bsy[1]}, 64'd0);
        start_dump(1);
        @(posedge clk); #1;
        rxd[1] = 8'h53; rxv[1] = 1'b1; sd[1] = 24'h000155; sv[1] = 1'b1;
        @(posedge clk); #1;
        rxv[1] = 1'b0; sv[1] = 1'b0;
        feed(1, 24'h0003FF);
        feed(1, 24'h00000A);
        wait_idle(1, 200, 1'b0);
        cmp_str(1, "w10", e_w10);

        // ---------------- decimation with random stalls, GAP=5 ----------------
        start_dump(2);
        send_cmd(2, 8'h73);
        for (int v = 1; v <= 6; v++) feed(2, 24'(v));
        wait_idle(2, 3000, 1'b1);
        cmp_str(2, "decim", e_dec);

        // ---------------- abort during third byte ----------------
        start_dump(0);
        tr[0] = 1'b0;
        send_cmd(0, 8'h73);
        feed(0, 24'h00ABCD);
        feed(0, 24'h111111);
        feed(0, 24'h222222);
        feed(0, 24'h333333);
        for (int b = 0; b < 2; b++) begin
            wait_tv(0, 50);
            @(posedge clk); #1 tr[0] = 1'b1;
            @(posedge clk); #1 tr[0] = 1'b0;
        end
        wait_tv(0, 50);
        send_cmd(0, 8'h61);
        repeat (4) @(negedge clk);
        check("abort_hold", {63'd0, tv[0]}, 64'd1);
        check("abort_count", 64'(rx_str[0].len()), 64'd2);
        @(posedge clk); #1 tr[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_busy", {63'd0, bsy[0]}, 64'd0);
        check("abort_valid", {63'd0, tv[0]}, 64'd0);
        cmp_str(0, "abort", e_abort);

        // recapture after abort
        start_dump(0);
        send_cmd(0, 8'h73);
        feed(0, 24'h000001);
        feed(0, 24'h00ABCD);
        feed(0, 24'hFFFFFF);
        feed(0, 24'h123456);
        wait_idle(0, 200, 1'b0);
        cmp_str(0, "recap", e_main);

`ifdef CAPTURE_TRIGGER_EN
        // ---------------- level trigger ----------------
        start_dump(0);
        send_cmd(0, 8'h74);
        @(negedge clk);
        check("arm_busy", {63'd0, bsy[0]}, 64'd1);
        feed(0, 24'h000010);
        feed(0, 24'h7FFFFF);
        feed(0, 24'h800000);
        feed(0, 24'h000020);
        feed(0, 24'h000001);
        feed(0, 24'h000002);
        wait_idle(0, 200, 1'b0);
        cmp_str(0, "trig", e_trig);
`endif

        // ---------------- reset mid-capture ----------------
        send_cmd(2, 8'h73);
        feed(2, 24'h000009);
        @(negedge clk);
        check("mid_busy", {63'd0, bsy[2]}, 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        #2;
        check("mid_rst_busy", {63'd0, bsy[2]}, 64'd0);
        check("mid_rst_rx_ready", {63'd0, rxr[2]}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", {63'd0, bsy[2]}, 64'd0);
        check("post_rst_rx_ready", {63'd0, rxr[2]}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sample_capture_dump.md
# sample_capture_dump

Parametrised successor to the single-shot ADC capture logic: buffers DEPTH samples of SAMPLE_WIDTH bits from a valid-strobed sample stream (normally sigma_delta_adc output) on a UART command, then streams them out as uppercase hex ASCII lines over a byte valid/ready interface to the uart block. Adds configurable width and depth, decimation, inter-byte pacing, abort, and an optional level trigger. Sits between the ADC and the uart instance in the top level.

## Interface
- SAMPLE_WIDTH, 24: bits per sample (1..64).
- DEPTH, 1024: samples per capture (power of two, ≥2).
- DECIMATE, 1: store every DECIMATE-th valid sample (≥1).
- GAP_CYCLES, 100: idle cycles between a tx handshake and the next tx_valid (0 allowed).
- TRIG_LEVEL, 0: unsigned trigger threshold (trigger build only).
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- sample_data  in  SAMPLE_WIDTH  ADC sample.
- sample_valid  in  1  one-cycle sample strobe.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  received byte available.
- rx_ready  out  1  command byte accepted.
- tx_data  out  8  ASCII byte to transmit.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  uart accepts byte.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, ARM (trigger build only), CAPTURE, DUMP.
- rx_ready registered, 1 in every state after reset; byte consumed on rx_valid & rx_ready. Unknown bytes ignored.
- 's'/'S' (0x73/0x53) in IDLE → CAPTURE; write pointer and decimation counter cleared. Ignored outside IDLE.
- 'a'/'A' (0x61/0x41): CAPTURE/ARM → IDLE next cycle, nothing transmitted. DUMP: if tx_valid high, hold it until handshake, then IDLE; otherwise IDLE next cycle.
- CAPTURE: every sample_valid increments the decimation counter; sample written when counter = DECIMATE-1 (counter wraps to 0). After the DEPTH-th write → DUMP. A sample_valid on the command-accept cycle is not captured.
- DUMP: per sample, NIB = ceil(SAMPLE_WIDTH/4) hex chars MSB first, top nibble zero-padded; 0–9 → 0x30+n, A–F → 0x37+n; then 0x0A, 0x0D. Samples in write order, index 0 first. After the final 0x0D handshake → IDLE. Total bytes DEPTH·(NIB+2).
- tx_data/tx_valid held stable from assertion until tx_valid & tx_ready; tx_valid never drops without handshake except under rst.

## Timing
- Reset values: rx_ready 0, tx_valid 0, tx_data 0x00, busy 0; state IDLE, all counters 0. Buffer contents not reset.
- Reset mid-operation: immediate return to IDLE, in-flight byte dropped.
- Command byte handshake at cycle N → busy high at N+1; capture eligible from N+1.
- Last capture write at cycle N → DUMP at N+1.
- Buffer read has 1-cycle registered latency. First tx_valid rises exactly GAP_CYCLES+2 cycles after entering DUMP; each subsequent tx_valid rises exactly GAP_CYCLES+2 cycles after the previous handshake cycle.
- tx_ready held high → one byte per GAP_CYCLES+3 cycles.

## Configuration
- CAPTURE_TRIGGER_EN defined: 't'/'T' in IDLE → ARM; in ARM, the first sample_valid with unsigned sample_data ≥ TRIG_LEVEL → CAPTURE and that sample is written as index 0 (decimation counter restarts from it). 'a' aborts ARM.
- Not defined: ARM absent, TRIG_LEVEL unused, 't' ignored as unknown byte.

## Structure
- Package capture_pkg: state enum, ASCII constants (LF, CR, command bytes), hex-to-ASCII function, NIB width function.
- Sub-module capture_ram: simple dual-port, 1 write / 1 registered read, DEPTH×SAMPLE_WIDTH, block-RAM inferable.

## Test plan
- W=24, D=4, DEC=1, GAP=0: send 's', feed 0x000001, 0x00ABCD, 0xFFFFFF, 0x123456 → bytes "000001\n\r00ABCD\n\rFFFFFF\n\r123456\n\r", then busy 0.
- W=10, D=2: samples 0x3FF, 0x00A → "3FF\n\r00A\n\r".
- DEC=3, D=2: feed 1..6 → stored 3, 6; output "000003\n\r000006\n\r".
- Random tx_ready stalls, GAP=5: tx_data stable while tx_valid high; spacing GAP_CYCLES+2 from handshake to next tx_valid.
- 'a' during third byte of dump with tx_ready low → byte completes on tx_ready, no further bytes, busy 0; next 's' recaptures normally.
- CAPTURE_TRIGGER_EN, TRIG_LEVEL=0x800000: 't', feed 0x10, 0x7FFFFF, 0x800000, 0x20 (D=2) → "800000\n\r000020\n\r".
